// File: rtl/mul_div_unit.sv
// ============================================================================
// Module   : mul_div_unit
// Purpose  : Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] c_last_step = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [1:0]             r_op;
  logic                   r_s1;
  logic                   r_s2;
  logic [WIDTH-1:0]       r_a;
  logic [WIDTH-1:0]       r_b;
  logic [WIDTH-1:0]       r_raw1;
  logic [CW-1:0]          r_cnt;
  logic [2*WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]       r_rem;
  logic [WIDTH-1:0]       r_hi;
  logic [WIDTH-1:0]       r_lo;
  logic                   r_done;
  logic                   r_dbz;

  // Operand magnitudes; signs only count for the signed opcodes (op_i[0]).
  logic                   w_sign1;
  logic                   w_sign2;
  logic [WIDTH-1:0]       w_abs1;
  logic [WIDTH-1:0]       w_abs2;
  logic [WIDTH:0]         w_mul_sum;
  logic [WIDTH:0]         w_div_shift;
  logic [WIDTH:0]         w_div_diff;
  logic [2*WIDTH-1:0]     w_prod_fix;
  logic [WIDTH-1:0]       w_quo_fix;
  logic [WIDTH-1:0]       w_rem_fix;
  logic                   w_b_zero;

  assign w_sign1 = op_i[0] & src1_i[WIDTH-1];
  assign w_sign2 = op_i[0] & src2_i[WIDTH-1];
  assign w_abs1  = w_sign1 ? -src1_i : src1_i;
  assign w_abs2  = w_sign2 ? -src2_i : src2_i;

  // Multiply: low half of r_acc holds the remaining multiplier bits.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                     (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});

  // Divide: r_acc[WIDTH-1:0] shifts dividend bits out and quotient bits in.
  assign w_div_shift = {r_rem, r_acc[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_b};

  assign w_prod_fix = (r_s1 ^ r_s2) ? -r_acc : r_acc;
  assign w_quo_fix  = (r_s1 ^ r_s2) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_s1 ? -r_rem : r_rem;
  assign w_b_zero   = (r_b == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_next = S_CALC;
      S_CALC:  if (r_cnt == c_last_step) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_op   <= '0;
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_raw1 <= '0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_rem  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            // A start wins over a same-cycle MTHI/MTLO, which is dropped.
            r_op   <= op_i;
            r_s1   <= w_sign1;
            r_s2   <= w_sign2;
            r_a    <= w_abs1;
            r_b    <= w_abs2;
            r_raw1 <= src1_i;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_acc  <= {{WIDTH{1'b0}}, (op_i[1] ? w_abs1 : w_abs2)};
          end else begin
            if (hi_we_i) r_hi <= wdata_i;
            if (lo_we_i) r_lo <= wdata_i;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_op[1]) begin
            if (!w_div_diff[WIDTH]) begin
              r_rem              <= w_div_diff[WIDTH-1:0];
              r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], 1'b1};
            end else begin
              r_rem              <= w_div_shift[WIDTH-1:0];
              r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], 1'b0};
            end
          end else begin
            r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          r_done <= 1'b1;
          if (r_op[1]) begin
            if (w_b_zero) begin
              r_hi  <= r_raw1;
              r_lo  <= '1;
              r_dbz <= 1'b1;
            end else begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o        = (r_state != S_IDLE);
  assign done_o        = r_done;
  assign div_by_zero_o = r_dbz;
  assign hi_o          = r_hi;
  assign lo_o          = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module   : tb_mul_div_unit
// Purpose  : Self-checking bench for mul_div_unit against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = '0;
  logic [31:0] src1_i = '0;
  logic [31:0] src2_i = '0;
  logic        hi_we_i = 1'b0;
  logic        lo_we_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic        busy_o;
  logic        done_o;
  logic        div_by_zero_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .src1_i(src1_i), .src2_i(src2_i), .hi_we_i(hi_we_i), .lo_we_i(lo_we_i),
    .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o),
    .div_by_zero_o(div_by_zero_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: plain 64-bit arithmetic on magnitudes, result as {HI, LO}.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [31:0] ma, mb, q, r;
    logic na, nb;
    if (!op[1]) begin
      if (op[0]) begin
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return 64'(sa * sb);
      end
      return {32'd0, a} * {32'd0, b};
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    na = op[0] & a[31];
    nb = op[0] & b[31];
    ma = na ? (32'd0 - a) : a;
    mb = nb ? (32'd0 - b) : b;
    q = ma / mb;
    r = ma % mb;
    if (na ^ nb) q = 32'd0 - q;
    if (na) r = 32'd0 - r;
    return {r, q};
  endfunction

  // Runs one operation and reports what was observed; callers do the checks.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] hi, output logic [31:0] lo,
                       output logic dbz, output logic busy_ok, output logic stable,
                       output logic after_ok);
    logic [31:0] h0, l0;
    bit found;
    h0 = hi_o; l0 = lo_o;
    lat = -1; hi = '0; lo = '0; dbz = 1'b0; busy_ok = 1'b1; stable = 1'b1; found = 0;
    op_i = op; src1_i = a; src2_i = b; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int k = 0; k <= 100 && !found; k++) begin
      if (k > 0) begin @(posedge clk_i); #1; end
      if (done_o) begin
        found = 1; lat = k; hi = hi_o; lo = lo_o; dbz = div_by_zero_o;
        if (busy_o) busy_ok = 1'b0;
      end else begin
        if (!busy_o || div_by_zero_o) busy_ok = 1'b0;
        if (hi_o !== h0 || lo_o !== l0) stable = 1'b0;
      end
    end
    @(posedge clk_i); #1;
    after_ok = !done_o && !div_by_zero_o && !busy_o;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk_i);
    #1;
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", busy_o); end
    n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done got %0b want 0", done_o); end
    n_vec++; if (div_by_zero_o !== 1'b0) begin n_err++; $display("FAIL reset_dbz got %0b want 0", div_by_zero_o); end
    n_vec++; if (hi_o !== 32'd0) begin n_err++; $display("FAIL reset_hi got %h want 0", hi_o); end
    n_vec++; if (lo_o !== 32'd0) begin n_err++; $display("FAIL reset_lo got %h want 0", lo_o); end
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL idle_busy got %0b want 0", busy_o); end
  endtask

  task automatic test_directed;
    logic [1:0]  ops [5] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd3};
    logic [31:0] as  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000};
    logic [31:0] bs  [5] = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF};
    int lat; logic [31:0] hi, lo; logic dbz, bok, stb, aok;
    logic [63:0] exp;
    for (int i = 0; i < 5; i++) begin
      exp = model(ops[i], as[i], bs[i]);
      do_op(ops[i], as[i], bs[i], lat, hi, lo, dbz, bok, stb, aok);
      n_vec++; if (lat !== 33) begin n_err++; $display("FAIL dir%0d_latency got %0d want 33", i, lat); end
      n_vec++; if ({hi, lo} !== exp) begin n_err++; $display("FAIL dir%0d_result got %h_%h want %h", i, hi, lo, exp); end
      n_vec++; if (dbz !== (ops[i][1] && bs[i] == 32'd0)) begin n_err++; $display("FAIL dir%0d_dbz got %0b", i, dbz); end
      n_vec++; if (!bok) begin n_err++; $display("FAIL dir%0d_busy got bad busy profile want 1 then 0", i); end
      n_vec++; if (!stb) begin n_err++; $display("FAIL dir%0d_hilo_stable got change during calc want none", i); end
      n_vec++; if (!aok) begin n_err++; $display("FAIL dir%0d_single_pulse got extra done/busy want idle", i); end
      m_hi = exp[63:32]; m_lo = exp[31:0];
    end
  endtask

  task automatic test_random;
    int lat; logic [31:0] a, b, hi, lo; logic [1:0] op; logic dbz, bok, stb, aok;
    logic [63:0] exp;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 15));
        default: ;
      endcase
      exp = model(op, a, b);
      do_op(op, a, b, lat, hi, lo, dbz, bok, stb, aok);
      n_vec++; if ({hi, lo} !== exp || lat !== 33) begin
        n_err++; $display("FAIL rnd%0d op%0d %h,%h got %h_%h lat %0d want %h lat 33", i, op, a, b, hi, lo, lat, exp);
      end
      n_vec++; if (dbz !== (op[1] && b == 32'd0) || !bok || !stb || !aok) begin
        n_err++; $display("FAIL rnd%0d_ctrl got dbz=%0b busy=%0b stable=%0b after=%0b", i, dbz, bok, stb, aok);
      end
      m_hi = exp[63:32]; m_lo = exp[31:0];
    end
  endtask

  task automatic test_mt;
    logic [31:0] v;
    int lat;
    bit found;
    hi_we_i = 1'b1; wdata_i = 32'h1234_5678;
    @(posedge clk_i); #1;
    hi_we_i = 1'b0;
    n_vec++; if (hi_o !== 32'h1234_5678) begin n_err++; $display("FAIL mthi got %h want 12345678", hi_o); end
    n_vec++; if (lo_o !== m_lo) begin n_err++; $display("FAIL mthi_lo got %h want %h", lo_o, m_lo); end
    v = $urandom;
    hi_we_i = 1'b1; lo_we_i = 1'b1; wdata_i = v;
    @(posedge clk_i); #1;
    hi_we_i = 1'b0; lo_we_i = 1'b0;
    n_vec++; if (hi_o !== v || lo_o !== v) begin n_err++; $display("FAIL mt_both got %h_%h want %h", hi_o, lo_o, v); end
    // start with a same-cycle MTLO, then MTLO/MTHI mid-operation
    op_i = 2'd0; src1_i = 32'd2; src2_i = 32'd3; start_i = 1'b1; lo_we_i = 1'b1; wdata_i = 32'hAAAA_5555;
    @(posedge clk_i); #1;
    start_i = 1'b0; lo_we_i = 1'b0;
    n_vec++; if (lo_o !== v) begin n_err++; $display("FAIL start_we_discard got %h want %h", lo_o, v); end
    repeat (4) @(posedge clk_i);
    #1; lo_we_i = 1'b1; hi_we_i = 1'b1;
    @(posedge clk_i); #1;
    lo_we_i = 1'b0; hi_we_i = 1'b0;
    lat = 5; found = 0;
    while (!found && lat < 100) begin
      if (done_o) found = 1;
      else begin @(posedge clk_i); #1; lat++; end
    end
    n_vec++; if (lat !== 33) begin n_err++; $display("FAIL busy_we_latency got %0d want 33", lat); end
    n_vec++; if (hi_o !== 32'd0 || lo_o !== 32'd6) begin n_err++; $display("FAIL busy_we_ignored got %h_%h want 0_6", hi_o, lo_o); end
    m_hi = 32'd0; m_lo = 32'd6;
    @(posedge clk_i); #1;
  endtask

  task automatic test_back_to_back;
    int nd = 0, t1 = -1, t2 = -1;
    logic [31:0] h1 = '0, l1 = '0, h2 = '0, l2 = '0;
    logic [63:0] e1, e2;
    e1 = model(2'd2, 32'd9, 32'd2);
    e2 = model(2'd2, 32'd1, 32'd1);
    op_i = 2'd2; src1_i = 32'd9; src2_i = 32'd2; start_i = 1'b1;
    @(posedge clk_i); #1;
    src1_i = 32'd1; src2_i = 32'd1;
    for (int k = 1; k <= 75; k++) begin
      @(posedge clk_i); #1;
      if (done_o) begin
        nd++;
        if (nd == 1) begin t1 = k; h1 = hi_o; l1 = lo_o; end
        if (nd == 2) begin t2 = k; h2 = hi_o; l2 = lo_o; end
      end
      if (k == 40) start_i = 1'b0;
    end
    n_vec++; if (t1 !== 33 || {h1, l1} !== e1) begin n_err++; $display("FAIL b2b_first got t=%0d %h_%h want t=33 %h", t1, h1, l1, e1); end
    n_vec++; if (t2 !== 67 || {h2, l2} !== e2) begin n_err++; $display("FAIL b2b_second got t=%0d %h_%h want t=67 %h", t2, h2, l2, e2); end
    n_vec++; if (nd !== 2) begin n_err++; $display("FAIL b2b_done_count got %0d want 2", nd); end
    m_hi = e2[63:32]; m_lo = e2[31:0];
  endtask

  task automatic test_reset_mid;
    int nd = 0;
    hi_we_i = 1'b1; wdata_i = 32'h0000_0055;
    @(posedge clk_i); #1;
    hi_we_i = 1'b0;
    op_i = 2'd0; src1_i = $urandom; src2_i = $urandom; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #4 rst_i = 1'b1;
    #1;
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got %0b want 0", busy_o); end
    n_vec++; if (hi_o !== 32'd0 || lo_o !== 32'd0) begin n_err++; $display("FAIL rst_mid_hilo got %h_%h want 0_0", hi_o, lo_o); end
    #3 rst_i = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk_i); #1;
      if (done_o || busy_o) nd++;
    end
    n_vec++; if (nd !== 0) begin n_err++; $display("FAIL rst_mid_no_done got %0d active cycles want 0", nd); end
    m_hi = '0; m_lo = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_mt();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle integer multiply/divide unit with architectural HI/LO registers. It sits beside the ALU in the execute stage and takes the same register-file read operands (RS/RT data). It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO. HI/LO results are read by the write-back path for MFHI/MFLO. The core controller waits on `busy_o`/`done_o`.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. HI and LO are each WIDTH bits.

Ports:
- `clk_i`  in  1  clock. All state updates on the rising edge.
- `rst_i`  in  1  reset. Asynchronous, active-high.
- `start_i`  in  1  request a new operation. Sampled only in IDLE.
- `op_i`  in  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `src1_i`  in  WIDTH  multiplicand or dividend (RS data).
- `src2_i`  in  WIDTH  multiplier or divisor (RT data).
- `hi_we_i`  in  1  MTHI write enable.
- `lo_we_i`  in  1  MTLO write enable.
- `wdata_i`  in  WIDTH  MTHI/MTLO data.
- `busy_o`  out  1  an operation is in progress.
- `done_o`  out  1  one-cycle pulse; HI/LO are updated with the result.
- `div_by_zero_o`  out  1  one-cycle pulse together with `done_o` when a divide had divisor 0.
- `hi_o`  out  WIDTH  HI register.
- `lo_o`  out  WIDTH  LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, `start_i`=1 at a clock edge:
  - latch `op_i`, `src1_i`, `src2_i`;
  - for signed ops, replace each operand by its absolute value and record the sign of each operand;
  - clear the iteration counter (5 bits) and go to CALC.
- CALC: one radix-2 step per cycle, 32 cycles total (counter 0..31). Leave for FIX when the counter reaches 31.
  - Multiply: unsigned shift-add into a 64-bit accumulator.
  - Divide: restoring division with a 33-bit partial remainder, producing one quotient bit per cycle.
- FIX: apply sign correction, write HI/LO, pulse `done_o`, return to IDLE.
  - Signed multiply: negate the 64-bit product if the operand signs differ.
  - Signed divide: quotient sign = XOR of the operand signs; remainder sign = sign of the dividend.
- Result mapping:
  - multiply: HI = product[63:32], LO = product[31:0];
  - divide: LO = quotient, HI = remainder.
- Divisor = 0 (DIV or DIVU): HI = raw latched `src1_i`, LO = 0xFFFFFFFF, `div_by_zero_o`=1. Latency is unchanged.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. This falls out of the magnitude path with wrap-around negation; no special case is needed.
- All arithmetic is modulo 2^WIDTH (2^64 for the product); negation is two's complement.
- MTHI/MTLO:
  - In IDLE, `hi_we_i`/`lo_we_i` write `wdata_i` to HI/LO at the edge. Both may be set in the same cycle, writing both registers.
  - They are ignored while busy.
  - If `start_i` and a write enable are both high in the same IDLE cycle, the start is accepted and the write is discarded.
- `start_i` while busy is ignored; it is not queued.
- HI/LO keep their old values throughout CALC. They change only in FIX or on an IDLE write.

## Timing
- Reset (asynchronous, any state): state = IDLE, HI = LO = 0, counter = 0, `busy_o`=0, `done_o`=0, `div_by_zero_o`=0. This includes reset mid-operation: the in-flight operation is abandoned and no `done_o` is produced.
- With start accepted at edge E0:
  - `busy_o`=1 from after E0 until E33;
  - CALC steps occur at edges E1..E32;
  - FIX completes at E33.
- After E33: `done_o`=1 for exactly one cycle, new `hi_o`/`lo_o` are visible, and `busy_o`=0.
- Total latency from start to result is 33 cycles.
- A new start may be accepted at E34, i.e. in the cycle in which `done_o` is high.
- `hi_o`/`lo_o` are driven directly from registers, with no combinational path from inputs.
- `busy_o` is decoded combinationally from state: 1 when state is not IDLE.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 33 cycles HI=0xFFFFFFFE, LO=0x00000001, single `done_o` pulse, `busy_o` low afterwards.
- MULT -3 (0xFFFFFFFD) × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 0 -> HI=0x00000064, LO=0xFFFFFFFF, `div_by_zero_o`=1 in the same cycle as `done_o`. Then DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, `div_by_zero_o`=0.
- MTHI 0x12345678 in IDLE -> `hi_o`=0x12345678 next cycle, LO unchanged. MTLO pulsed at cycle 5 of a MULTU 2×3 -> ignored; final HI=0, LO=6.
- `start_i` held high for 40 cycles with a DIVU 9/2 (operands changing to 1/1 after the first cycle) -> the first result is HI=1, LO=4 at cycle 33; a second op (1/1) is accepted at E34 and gives HI=0, LO=1 at E67.
- Start MULTU, assert `rst_i` at cycle 10 -> immediately `busy_o`=0, HI=LO=0, and no `done_o` ever appears for that operation.
